// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI4-Stream flit FIFO: flit width, routing field offsets
// and the constant log2 helper used to size pointers.
package axis_fifo_pkg;

    localparam int FLIT_W   = 42;
    localparam int DEST_LSB = 32;
    localparam int DEST_MSB = 38;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage for axis_fifo: synchronous write, asynchronous read so the
// word at the read pointer is visible immediately (first-word-fall-through).
module axis_fifo_mem
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [clog2(DEPTH)-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [clog2(DEPTH)-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_fifo.sv
// Single-clock AXI4-Stream FWFT FIFO with registered tready/tvalid flags.
// Optional registered occupancy output enabled by AXIS_FIFO_DATA_COUNT_EN.
module axis_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int DEPTH      = 16
) (
    input  logic                    s_aclk,
    input  logic                    s_areset,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata
`ifdef AXIS_FIFO_DATA_COUNT_EN
    ,
    output logic [clog2(DEPTH):0]   axis_data_count
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          tready_q, tready_d;
    logic          tvalid_q, tvalid_d;
    logic          wr_fire;
    logic          rd_fire;

    // MSB of each pointer is the wrap flag: equal low bits with differing wrap means full.
    function automatic logic ptr_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    endfunction

    always_comb begin
        wr_fire  = s_axis_tvalid & tready_q;
        rd_fire  = tvalid_q & m_axis_tready;
        wr_ptr_d = wr_ptr_q + PW'(wr_fire);
        rd_ptr_d = rd_ptr_q + PW'(rd_fire);
        tready_d = !ptr_full(wr_ptr_d, rd_ptr_d);
        tvalid_d = (wr_ptr_d != rd_ptr_d);
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
        end
    end

    axis_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (s_aclk),
        .we    (wr_fire & ~s_areset),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (m_axis_tdata)
    );

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = tvalid_q;

`ifdef AXIS_FIFO_DATA_COUNT_EN
    logic [PW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (wr_fire && !rd_fire) begin
            count_d = count_q + 1'b1;
        end else if (rd_fire && !wr_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign axis_data_count = count_q;
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// Directed and random self-checking bench for axis_fifo (DEPTH=16, 42-bit flits).
module tb_axis_fifo;

    localparam int DW = 42;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef AXIS_FIFO_DATA_COUNT_EN
    logic [4:0]    data_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];

    axis_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .s_aclk        (clk),
        .s_areset      (rst),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tdata  (s_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_data)
`ifdef AXIS_FIFO_DATA_COUNT_EN
        ,
        .axis_data_count (data_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          pop;
        logic          push;

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tvalid", 64'(m_valid), 64'd0);
            check("rst_tready", 64'(s_ready), 64'd0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_tready", 64'(s_ready), 64'd1);
        check("post_rst_tvalid", 64'(m_valid), 64'd0);
`ifdef AXIS_FIFO_DATA_COUNT_EN
        check("post_rst_count", 64'(data_count), 64'd0);
`endif

        // Single word, held until popped
        s_valid = 1'b1;
        s_data = 42'h0_05_DEADBEEF;
        tick();
        s_valid = 1'b0;
        s_data = '0;
        check("single_tvalid", 64'(m_valid), 64'd1);
        check("single_tdata", 64'(m_data), 64'h005DEADBEEF);
        tick();
        tick();
        check("single_hold_tvalid", 64'(m_valid), 64'd1);
        check("single_hold_tdata", 64'(m_data), 64'h005DEADBEEF);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("single_pop_tvalid", 64'(m_valid), 64'd0);

        // Fill to full, then attempt a 17th write
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data = DW'(i);
            tick();
            check("fill_tready", 64'(s_ready), (i == 15) ? 64'd0 : 64'd1);
        end
`ifdef AXIS_FIFO_DATA_COUNT_EN
        check("full_count", 64'(data_count), 64'd16);
`endif
        s_data = DW'(99);
        tick();
        s_valid = 1'b0;
        check("overflow_tready", 64'(s_ready), 64'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_tvalid", 64'(m_valid), 64'd1);
            check("drain_tdata", 64'(m_data), 64'(i));
            tick();
        end
        m_ready = 1'b0;
        check("drain_empty", 64'(m_valid), 64'd0);

        // Eight stored, then simultaneous push/pop across pointer wrap
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data = DW'(100 + i);
            tick();
        end
        m_ready = 1'b1;
        for (int j = 0; j < 40; j++) begin
            s_data = DW'(108 + j);
            check("simul_tready", 64'(s_ready), 64'd1);
            check("simul_tvalid", 64'(m_valid), 64'd1);
            check("simul_tdata", 64'(m_data), 64'(100 + j));
            tick();
        end
        s_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("simul_drain", 64'(m_data), 64'(140 + j));
            tick();
        end
        m_ready = 1'b0;
        check("simul_empty", 64'(m_valid), 64'd0);

        // Reset with five words stored; word presented during reset is dropped
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = DW'(200 + i);
            tick();
        end
        rst = 1'b1;
        s_data = DW'(12'h3FF);
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        check("midrst_tvalid", 64'(m_valid), 64'd0);
        tick();
        check("midrst_tvalid2", 64'(m_valid), 64'd0);
        check("midrst_tready", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_data = DW'(12'h555);
        tick();
        s_valid = 1'b0;
        check("midrst_new_tdata", 64'(m_data), 64'h555);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("midrst_new_empty", 64'(m_valid), 64'd0);

        // Random traffic against a queue model
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            s_valid = 1'($urandom_range(1));
            m_ready = 1'($urandom_range(1));
            s_data = DW'({$urandom, $urandom});
            check("rand_tvalid", 64'(m_valid), 64'(q.size() != 0));
            check("rand_tready", 64'(s_ready), 64'(q.size() < DEPTH));
            if (q.size() != 0) begin
                check("rand_tdata", 64'(m_data), 64'(q[0]));
            end
`ifdef AXIS_FIFO_DATA_COUNT_EN
            check("rand_count", 64'(data_count), 64'(q.size()));
`endif
            pop  = m_ready && (q.size() != 0);
            push = s_valid && (q.size() < DEPTH);
            if (pop) begin
                rd = q.pop_front();
            end
            if (push) begin
                q.push_back(s_data);
            end
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
